// File: rtl/q7_mul_pkg.sv
// Shared types and default constants for the shift-add multiplier
// dispatcher/collector.
package q7_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } q7_mul_state_t;

  localparam int Q7_N       = 8;
  localparam int Q7_TIMEOUT = 64;

endpackage

// File: rtl/q7_watchdog.sv
// Clear/enable up-counter with a terminal-count flag.
// Ports:
//   clk, reset  - clock, async active-high reset
//   clr_i       - synchronous clear to zero (wins over enable)
//   en_i        - count one step this cycle
//   term_o      - count has reached TIMEOUT-1
module q7_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/q7_shiftaddmul_ctrl.sv
// Operand dispatcher and product collector for a start/stop shift-add
// multiplier. Accepts B/Q pairs on a valid/ready handshake, holds the
// multiplier start high until stop, captures the product and offers it
// downstream on a second valid/ready handshake. A watchdog aborts an
// operation whose stop never arrives (TIMEOUT must be >= 2).
//
// Ports:
//   clk, reset              - clock, async active-high reset
//   i_valid / o_ready       - upstream operand handshake, i_B / i_Q operands
//   o_mul_start             - multiplier start (registered state decode)
//   o_mul_B / o_mul_Q       - registered operands to the multiplier
//   i_mul_stop / i_mul_A    - multiplier done flag and 2N-bit product
//   o_valid / i_ready       - downstream product handshake, o_P product
//   o_err                   - one-cycle pulse after a watchdog abort
//   o_count                 - completed products, wraps at 16 bits
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new operand pair, start low
// RUN   | start high, waiting for stop, watchdog counting
// DONE  | product held on o_P with o_valid high until downstream accepts
module q7_shiftaddmul_ctrl
  import q7_mul_pkg::*;
#(
  parameter  int N       = Q7_N,
  parameter  int TIMEOUT = Q7_TIMEOUT,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_B,
  input  logic [N-1:0]   i_Q,
  output logic           o_mul_start,
  output logic [N-1:0]   o_mul_B,
  output logic [N-1:0]   o_mul_Q,
  input  logic           i_mul_stop,
  input  logic [2*N-1:0] i_mul_A,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_P,
  output logic           o_err,
  output logic [15:0]    o_count
);

  q7_mul_state_t  state_q, state_d;
  logic [N-1:0]   b_q, b_d, q_q, q_d;
  logic [2*N-1:0] p_q, p_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           wd_clr, wd_en, wd_term;

  q7_watchdog #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .term_o(wd_term)
  );

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          b_d     = i_B;
          q_d     = i_Q;
          wd_clr  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        wd_en = 1'b1;
        // stop takes priority over a terminal count on the same edge
        if (i_mul_stop) begin
          p_d     = i_mul_A;
          cnt_d   = cnt_q + 16'd1;
          state_d = DONE;
        end else if (wd_term) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        // returning through IDLE keeps start low for at least one cycle
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ready is masked by reset so it reads 0 while reset is held
  assign o_ready     = (state_q == IDLE) && !reset;
  assign o_mul_start = (state_q == RUN);
  assign o_valid     = (state_q == DONE);
  assign o_mul_B     = b_q;
  assign o_mul_Q     = q_q;
  assign o_P         = p_q;
  assign o_err       = err_q;
  assign o_count     = cnt_q;

endmodule

// File: doc/q7_shiftaddmul_ctrl.md
# q7_shiftaddmul_ctrl

Operand dispatcher and result collector that sits directly upstream of the shift-add multiplier (`start`/`stop` protocol, N-bit B/Q operands, 2N-bit product `o_A`). It accepts operand pairs over a valid/ready handshake and drives the multiplier's `start` until `stop` is seen. It captures the product and presents it downstream over a second valid/ready handshake. A watchdog aborts operations whose `stop` never arrives.

## Interface
- `N`, default 8, operand width; product is 2N bits.
- `TIMEOUT`, default 64, max cycles `o_mul_start` may stay high without `i_mul_stop`; must be ≥ 2.
- `CW`, default `$clog2(TIMEOUT+1)`, watchdog counter width (derived, not overridden).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `i_valid` in 1: upstream operand pair valid.
- `o_ready` out 1: block can accept a pair.
- `i_B` in N: multiplicand.
- `i_Q` in N: multiplier.
- `o_mul_start` out 1: to multiplier `start`.
- `o_mul_B` out N: to multiplier `i_B`, registered.
- `o_mul_Q` out N: to multiplier `i_Q`, registered.
- `i_mul_stop` in 1: from multiplier `stop`.
- `i_mul_A` in 2N: from multiplier `o_A`.
- `o_valid` out 1: product available.
- `i_ready` in 1: downstream accepts product.
- `o_P` out 2N: captured product.
- `o_err` out 1: one-cycle pulse on watchdog abort.
- `o_count` out 16: completed products, wraps 0xFFFF→0.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** `o_ready`=1, `o_mul_start`=0.
  - `i_valid`=1 at an edge: latch `i_B` and `i_Q` into `o_mul_B` and `o_mul_Q`, clear the watchdog, go to RUN.
- **RUN:** `o_ready`=0, `o_mul_start`=1, `o_mul_B` and `o_mul_Q` stable.
  - Watchdog increments every RUN cycle.
  - `i_mul_stop`=1 at an edge: `o_P`←`i_mul_A`, `o_count`+1, go to DONE.
  - Otherwise, if watchdog = TIMEOUT−1: pulse `o_err` for the next cycle, go to IDLE. `o_P` is unchanged, no `o_valid`.
  - `i_mul_stop` sampled only in RUN; a stop seen in IDLE or DONE is ignored.
- **DONE:** `o_valid`=1, `o_mul_start`=0, `o_P` held.
  - `i_ready`=1 at an edge: go to IDLE.
  - This guarantees `start` is low ≥1 cycle between operations, as the multiplier requires.
- **Overlap rule:** `i_valid` while not in IDLE is not accepted; upstream must hold its data.
- **Width:** `o_P` is exactly the 2N-bit multiplier output, no truncation. The unsigned product of two N-bit values always fits.

## Timing
- **Reset values:** `o_ready`=0 while `reset`=1, then 1 from the first cycle after release. `o_mul_start`=0, `o_mul_B`=0, `o_mul_Q`=0, `o_valid`=0, `o_P`=0, `o_err`=0, `o_count`=0, state=IDLE.
- **Accept to start:** accept at edge k; `o_mul_start` high from k (registered) until the edge where stop is sampled.
- **Stop to valid:** stop sampled at edge m; `o_valid` and `o_P` valid after m; `o_mul_start` low after m.
- **Throughput:** next accept no earlier than the edge after the DONE handshake. Minimum period is multiplier latency + 2 cycles.
- **Same-edge events:**
  - Watchdog terminal and `i_mul_stop` at the same edge: stop wins, the product is captured, no error.
  - `o_valid` and `i_ready` at the same edge: IDLE next cycle; a simultaneous upstream `i_valid` is not accepted that edge.
- **Reset mid-RUN:** `o_mul_start` drops asynchronously; the in-flight product is discarded; `o_count` is cleared.

## Structure
- **Package `q7_mul_pkg`:**
  - state enum `q7_mul_state_t` {IDLE, RUN, DONE};
  - default constants `Q7_N`=8 and `Q7_TIMEOUT`=64.
- **Sub-module `q7_watchdog`:** clear/enable counter with a terminal-count output, parameterised by TIMEOUT.
- The FSM, operand registers and product register live in the top module.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- **Basic product:** reset, then B=17, Q=46 with `i_valid`; model asserts stop after 8 cycles → `o_mul_start` high ~8 cycles, `o_valid`=1, `o_P`=782 (0x030E), `o_count`=1.
- **Backpressure:** `i_ready`=0 for 5 cycles after valid → `o_P` stable at 0x030E, `o_ready`=0, `o_mul_start`=0 throughout. Accept, then `o_ready`=1 next cycle.
- **Back-to-back:** pairs 255×255, then 0×200 with `i_valid` held → `o_P`=65025 then 0, `o_count`=2, `o_mul_start` low ≥1 cycle between.
- **Timeout:** model never asserts stop, TIMEOUT=64 → after 64 cycles in RUN `o_err` pulses one cycle, `o_valid` never rises, `o_count` unchanged, `o_ready`=1 next cycle.
- **Reset mid-op:** assert `reset` 3 cycles into RUN → `o_mul_start` drops in the same cycle, all outputs at reset values. A subsequent 3×5 yields `o_P`=15, `o_count`=1.
- **Stop at terminal count:** stop arrives exactly on the cycle the watchdog hits terminal → product captured, `o_err`=0.
